// File: rtl/aes256_pkg.sv
// aes256_pkg: shared AES-256 key-schedule constants, round-key type and store FSM states.
// Build option: AES_RKEY_ZEROIZE_EN adds the ST_ZERO wipe state to rkst_e.
package aes256_pkg;

    localparam int NK      = 8;
    localparam int NB      = 4;
    localparam int NR      = NK + 6;
    localparam int N_RKEYS = NR + 1;
    localparam int RK_W    = 32 * NB;
    localparam int IDX_W   = $clog2(N_RKEYS);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef logic [127:0] rkey_t;

    typedef enum logic [2:0] {
        ST_EMPTY = 3'd0,
        ST_LOAD  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_FULL  = 3'd3
`ifdef AES_RKEY_ZEROIZE_EN
        ,
        ST_ZERO  = 3'd4
`endif
    } rkst_e;

    // Decrypt walks the schedule backwards: round r uses slot NR-r.
    function automatic logic [IDX_W-1:0] phys_slot(
        input logic [IDX_W-1:0] idx,
        input logic             dec
    );
        return dec ? (LAST_IDX - idx) : idx;
    endfunction

endpackage

// File: rtl/aes256_rkey_ram.sv
// aes256_rkey_ram: 15 x 128 round-key array, one write and one registered read port.
// A same-cycle read of the slot being written returns the old contents.
module aes256_rkey_ram
    import aes256_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [RK_W-1:0]  wdata,
    input  logic             re,
    input  logic [IDX_W-1:0] raddr,
    output logic [RK_W-1:0]  rdata
);

    rkey_t mem [N_RKEYS];

    // Key storage; contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (we && (waddr <= LAST_IDX)) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register holds its value between accepted reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re && (raddr <= LAST_IDX)) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/aes256_rkey_store.sv
// aes256_rkey_store: captures the 15-key AES-256 expansion burst and serves keys by round.
// Build option: AES_RKEY_ZEROIZE_EN makes reset/kz_clear wipe all slots through ST_ZERO.
module aes256_rkey_store
    import aes256_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             kg_valid,
    input  logic [RK_W-1:0]  kg_data,
    input  logic             kz_clear,
    input  logic             rk_req,
    input  logic [IDX_W-1:0] rk_idx,
    input  logic             rk_dec,
    output logic             rk_ready,
    output logic             rk_valid,
    output logic [RK_W-1:0]  rk_data,
    output logic             rk_err,
    output logic             ld_err
);

`ifdef AES_RKEY_ZEROIZE_EN
    localparam rkst_e RST_ST = ST_ZERO;
    localparam rkst_e CLR_ST = ST_ZERO;
`else
    localparam rkst_e RST_ST = ST_EMPTY;
    localparam rkst_e CLR_ST = ST_EMPTY;
`endif

    rkst_e            st;
    logic [IDX_W-1:0] beat_cnt;

    logic             rd_ok;
    logic [IDX_W-1:0] raddr;

    logic             we;
    logic [IDX_W-1:0] waddr;
    logic [RK_W-1:0]  wdata;

    assign rd_ok = rk_req && rk_ready && (rk_idx <= LAST_IDX);
    assign raddr = phys_slot(rk_idx, rk_dec);

    // Write port: a burst's first beat lands in slot 0, later beats at beat_cnt.
    always_comb begin
        we    = 1'b0;
        waddr = beat_cnt;
        wdata = kg_data;
        if (!reset && !kz_clear) begin
            unique case (st)
                ST_EMPTY, ST_FULL: begin
                    we    = kg_valid;
                    waddr = '0;
                end
                ST_LOAD: begin
                    we = kg_valid;
                end
`ifdef AES_RKEY_ZEROIZE_EN
                ST_ZERO: begin
                    we    = 1'b1;
                    wdata = '0;
                end
`endif
                default: begin
                    we = 1'b0;
                end
            endcase
        end
    end

    // Load sequencing; rk_ready is registered so it is high exactly while in ST_FULL.
    always_ff @(posedge clk) begin
        if (reset) begin
            st       <= RST_ST;
            beat_cnt <= '0;
            rk_ready <= 1'b0;
            ld_err   <= 1'b0;
        end else begin
            rk_ready <= 1'b0;
            ld_err   <= 1'b0;
            if (kz_clear) begin
                st       <= CLR_ST;
                beat_cnt <= '0;
            end else begin
                unique case (st)
                    ST_EMPTY: begin
                        if (kg_valid) begin
                            st       <= ST_LOAD;
                            beat_cnt <= IDX_ONE;
                        end
                    end
                    ST_LOAD: begin
                        if (kg_valid) begin
                            beat_cnt <= beat_cnt + IDX_ONE;
                            if (beat_cnt == LAST_IDX) begin
                                st <= ST_HOLD;
                            end
                        end else begin
                            ld_err   <= 1'b1;
                            beat_cnt <= '0;
                            st       <= ST_EMPTY;
                        end
                    end
                    ST_HOLD: begin
                        if (!kg_valid) begin
                            st       <= ST_FULL;
                            rk_ready <= 1'b1;
                        end
                    end
                    ST_FULL: begin
                        if (kg_valid) begin
                            st       <= ST_LOAD;
                            beat_cnt <= IDX_ONE;
                        end else begin
                            rk_ready <= 1'b1;
                        end
                    end
`ifdef AES_RKEY_ZEROIZE_EN
                    ST_ZERO: begin
                        if (beat_cnt == LAST_IDX) begin
                            st       <= ST_EMPTY;
                            beat_cnt <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + IDX_ONE;
                        end
                    end
`endif
                    default: begin
                        st       <= ST_EMPTY;
                        beat_cnt <= '0;
                    end
                endcase
            end
        end
    end

    // Read handshake flags, one cycle behind the request.
    always_ff @(posedge clk) begin
        if (reset) begin
            rk_valid <= 1'b0;
            rk_err   <= 1'b0;
        end else begin
            rk_valid <= rd_ok;
            rk_err   <= rk_req && !rd_ok;
        end
    end

    aes256_rkey_ram u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .re    (rd_ok),
        .raddr (raddr),
        .rdata (rk_data)
    );

endmodule

// File: tb/tb_aes256_rkey_store.sv
// tb_aes256_rkey_store: directed plan plus randomized bursts/reads against a burst-level model.
// Honours AES_RKEY_ZEROIZE_EN the same way as the design.
module tb_aes256_rkey_store;
    import aes256_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         kg_valid;
    logic [127:0] kg_data;
    logic         kz_clear;
    logic         rk_req;
    logic [3:0]   rk_idx;
    logic         rk_dec;
    logic         rk_ready;
    logic         rk_valid;
    logic [127:0] rk_data;
    logic         rk_err;
    logic         ld_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    aes256_rkey_store dut (
        .clk      (clk),
        .reset    (reset),
        .kg_valid (kg_valid),
        .kg_data  (kg_data),
        .kz_clear (kz_clear),
        .rk_req   (rk_req),
        .rk_idx   (rk_idx),
        .rk_dec   (rk_dec),
        .rk_ready (rk_ready),
        .rk_valid (rk_valid),
        .rk_data  (rk_data),
        .rk_err   (rk_err),
        .ld_err   (ld_err)
    );

    // Reference model: keys as an array, a load as a counted burst.
    logic [127:0] m_mem [15];
    bit           m_ready;
    bit           m_in_burst;
    int           m_beats;
    int           m_zero_left;
    bit           m_valid;
    bit           m_err;
    bit           m_lderr;
    logic [127:0] m_data;

    localparam logic [127:0] DEAD = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

    task automatic check_eq(string tag, logic [127:0] got, logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_step();
        int slot;
        if (reset) begin
            m_ready     = 0;
            m_in_burst  = 0;
            m_beats     = 0;
            m_valid     = 0;
            m_err       = 0;
            m_lderr     = 0;
            m_data      = '0;
`ifdef AES_RKEY_ZEROIZE_EN
            m_zero_left = 15;
`else
            m_zero_left = 0;
`endif
            return;
        end
        // Reads see the contents from before this cycle's write.
        if (rk_req && m_ready && (int'(rk_idx) <= 14)) begin
            slot    = rk_dec ? 14 - int'(rk_idx) : int'(rk_idx);
            m_valid = 1;
            m_err   = 0;
            m_data  = m_mem[slot];
        end else begin
            m_valid = 0;
            m_err   = rk_req;
        end
        m_lderr = 0;
        if (kz_clear) begin
            m_ready    = 0;
            m_in_burst = 0;
            m_beats    = 0;
`ifdef AES_RKEY_ZEROIZE_EN
            m_zero_left = 15;
`endif
        end else if (m_zero_left > 0) begin
            m_mem[15 - m_zero_left] = '0;
            m_zero_left--;
        end else if (kg_valid) begin
            if (!m_in_burst) begin
                m_in_burst = 1;
                m_beats    = 0;
                m_ready    = 0;
            end
            if (m_beats < 15) m_mem[m_beats] = kg_data;
            m_beats++;
        end else if (m_in_burst) begin
            m_in_burst = 0;
            if (m_beats < 15) m_lderr = 1;
            else m_ready = 1;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_eq("rk_ready", 128'(rk_ready), 128'(m_ready));
        check_eq("rk_valid", 128'(rk_valid), 128'(m_valid));
        check_eq("rk_err", 128'(rk_err), 128'(m_err));
        check_eq("ld_err", 128'(ld_err), 128'(m_lderr));
        check_eq("rk_data", rk_data, m_data);
    endtask

    task automatic idle_inputs();
        kg_valid = 0;
        kg_data  = '0;
        kz_clear = 0;
        rk_req   = 0;
        rk_idx   = '0;
        rk_dec   = 0;
    endtask

    task automatic burst(int n, bit seq);
        for (int i = 0; i < n; i++) begin
            kg_valid = 1;
            kg_data  = seq ? 128'(i) : rnd128();
            cycle();
        end
        kg_valid = 0;
    endtask

    task automatic read(logic [3:0] idx, logic dec);
        rk_req = 1;
        rk_idx = idx;
        rk_dec = dec;
        cycle();
        rk_req = 0;
    endtask

    initial begin
        int burst_left;
        int gap;
        int r;

        idle_inputs();
        reset = 1;
        cycle();
        cycle();
        check_eq("rst_ready", 128'(rk_ready), 128'(0));
        check_eq("rst_data", rk_data, 128'(0));
        reset = 0;
`ifdef AES_RKEY_ZEROIZE_EN
        repeat (16) cycle();
`endif

        // 1: full load then a forward read
        burst(15, 1);
        check_eq("t1_not_ready_hold", 128'(rk_ready), 128'(0));
        cycle();
        check_eq("t1_ready", 128'(rk_ready), 128'(1));
        read(4'd3, 0);
        check_eq("t1_data", rk_data, 128'h3);

        // 2: decrypt order, back to back
        rk_req = 1;
        rk_dec = 1;
        rk_idx = 4'd0;
        cycle();
        check_eq("t2_dec0", rk_data, 128'hE);
        rk_idx = 4'd14;
        cycle();
        check_eq("t2_dec14", rk_data, 128'h0);
        check_eq("t2_valid", 128'(rk_valid), 128'(1));
        rk_req = 0;
        rk_dec = 0;

        // 3: overrun beats are ignored
        for (int i = 0; i < 17; i++) begin
            kg_valid = 1;
            kg_data  = (i < 15) ? 128'(i) : DEAD;
            cycle();
        end
        kg_valid = 0;
        cycle();
        check_eq("t3_lderr", 128'(ld_err), 128'(0));
        read(4'd14, 0);
        check_eq("t3_slot14", rk_data, 128'hE);

        // 4: aborted load, then a rejected read
        burst(7, 0);
        cycle();
        check_eq("t4_lderr", 128'(ld_err), 128'(1));
        check_eq("t4_ready", 128'(rk_ready), 128'(0));
        read(4'd2, 0);
        check_eq("t4_rkerr", 128'(rk_err), 128'(1));
        check_eq("t4_valid", 128'(rk_valid), 128'(0));

        // 5: bad index, then a read racing a reload
        burst(15, 1);
        cycle();
        read(4'd15, 0);
        check_eq("t5_idx15_err", 128'(rk_err), 128'(1));
        rk_req   = 1;
        rk_idx   = 4'd0;
        kg_valid = 1;
        kg_data  = DEAD;
        cycle();
        rk_req = 0;
        check_eq("t5_old_slot0", rk_data, 128'h0);
        check_eq("t5_ready_drop", 128'(rk_ready), 128'(0));
        for (int i = 1; i < 15; i++) begin
            kg_data = 128'(i);
            cycle();
        end
        kg_valid = 0;
        cycle();

        // 6: clear from FULL
        kz_clear = 1;
        cycle();
        kz_clear = 0;
        check_eq("t6_ready", 128'(rk_ready), 128'(0));
`ifdef AES_RKEY_ZEROIZE_EN
        repeat (15) cycle();
        for (int i = 0; i < 15; i++) begin
            check_eq("t6_zero", dut.u_ram.mem[i], 128'(0));
        end
`else
        cycle();
        check_eq("t6_state", 128'(dut.st), 128'(ST_EMPTY));
        check_eq("t6_slot0", dut.u_ram.mem[0], DEAD);
        for (int i = 1; i < 15; i++) begin
            check_eq("t6_keep", dut.u_ram.mem[i], 128'(i));
        end
`endif

        // Randomized traffic
        burst_left = 0;
        gap        = 2;
        for (int c = 0; c < 4000; c++) begin
            if (burst_left == 0 && gap == 0) begin
                r          = int'($urandom_range(0, 9));
                burst_left = (r < 7) ? int'($urandom_range(15, 17))
                                     : int'($urandom_range(1, 14));
                gap        = int'($urandom_range(1, 30));
            end
            if (burst_left > 0) begin
                kg_valid = 1;
                kg_data  = rnd128();
                burst_left--;
            end else begin
                kg_valid = 0;
                gap--;
            end
            rk_req   = ($urandom_range(0, 1) == 1);
            rk_idx   = 4'($urandom_range(0, 15));
            rk_dec   = ($urandom_range(0, 1) == 1);
            kz_clear = ($urandom_range(0, 99) < 2);
            reset    = ($urandom_range(0, 199) == 0);
            cycle();
        end
        idle_inputs();
        reset = 0;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/aes256_rkey_store.md
Name: aes256_rkey_store

Overview:
- Round-key buffer sitting directly downstream of the AES-256 key expansion block.
- Captures the 15 expanded 128-bit round keys from the expansion output burst (valid strobe plus 128-bit data per beat).
- Serves them to the cipher/decipher round engine by round index, in forward (encrypt) or reverse (decrypt) order, with a one-cycle registered read.
- Decouples the keygen's free-running output burst from the round engine's per-round key fetches.

Parameters:
- N_RKEYS, 15, number of round keys stored (Nr+1).
- RK_W, 128, round-key width in bits.
- IDX_W, 4, round-index width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- kg_valid  in  1  keygen output strobe; high for the whole burst, may stay high past 15 beats.
- kg_data  in  RK_W  keygen round-key beat. Byte 0 of word 0 is in [7:0]. Stored unmodified.
- kz_clear  in  1  single-cycle request to discard the stored keys.
- rk_req  in  1  round-key read request.
- rk_idx  in  IDX_W  requested round number, 0..14.
- rk_dec  in  1  1 = decrypt order: physical slot = 14 - rk_idx.
- rk_ready  out  1  all 15 keys loaded and readable.
- rk_valid  out  1  read data valid, one cycle after an accepted rk_req.
- rk_data  out  RK_W  read data.
- rk_err  out  1  one-cycle pulse on a rejected read.
- ld_err  out  1  one-cycle pulse on an aborted load.

Behaviour:
- Reset values: rk_ready=0, rk_valid=0, rk_data=0, rk_err=0, ld_err=0, state=EMPTY, beat_cnt=0. Storage array contents are not reset.
- FSM states: EMPTY, LOAD, HOLD, FULL, plus ZERO (present only with the optional feature).
- EMPTY:
  - kg_valid=1 → write kg_data to slot 0, beat_cnt=1, go to LOAD.
- LOAD:
  - kg_valid=1 → write slot[beat_cnt], beat_cnt+1. When slot 14 is written, go to HOLD.
  - kg_valid=0 before slot 14 is written → ld_err pulse, beat_cnt=0, go to EMPTY (partial load is discarded).
- HOLD:
  - Beats 16 and beyond (keygen overrun/repeat) are ignored; storage is not written.
  - kg_valid=0 → go to FULL.
- FULL:
  - rk_ready=1 (registered, asserted the cycle after entering FULL).
  - kg_valid=1 → reload: write slot 0, beat_cnt=1, go to LOAD, rk_ready=0 next cycle.
- rk_ready is high only in FULL.
- Read acceptance: a read is accepted when rk_req=1, rk_ready=1 and rk_idx<=14.
  - Next cycle: rk_valid=1, rk_data=slot[rk_dec ? 14-rk_idx : rk_idx].
  - rk_valid is otherwise 0; rk_data holds its last value.
- Read rejection: rk_req=1 with rk_ready=0 or rk_idx>14 → rk_err pulse next cycle, rk_valid=0.
- Back-to-back reads: one per cycle, fully pipelined.
- Read and reload in the same cycle: the read is accepted (rk_ready still 1) and returns the pre-write contents (read-before-write on slot 0).
- kz_clear has priority over kg_valid in every state: go to EMPTY (or ZERO), ld_err not asserted, rk_ready=0 next cycle.
- kz_clear together with rk_req: the read is still served if rk_ready was 1 that cycle.
- Reset mid-load: everything returns to reset values; a subsequent kg_valid burst starts a fresh load at slot 0.
- Index arithmetic: 4-bit unsigned; 14-rk_idx is computed only for rk_idx<=14.

Optional Feature:
- Macro: AES_RKEY_ZEROIZE_EN.
- Defined: kz_clear enters ZERO, which writes 0 to slots 0..14 over 15 cycles using beat_cnt, then goes to EMPTY. kg_valid is ignored during ZERO, and reads are rejected with rk_err. Reset also enters ZERO instead of EMPTY.
- Undefined: no ZERO state; kz_clear goes directly to EMPTY and storage contents are retained (only invalidated).

Decomposition:
- Shared package aes256_pkg holds:
  - constants NK=8, NB=4, NR=14, N_RKEYS=NR+1, RK_W=128;
  - typedef rkey_t (logic [127:0]);
  - enum rkst_e for the FSM states.
- One sub-module, aes256_rkey_ram: a 15×128 single-write, single-read registered array (write enable, write address, read address, registered read data, read-before-write). The FSM and index mapping stay in the top.

Test Plan:
1. Burst of 15 beats, kg_data=128'h00..0i for i=0..14, then kg_valid low → rk_ready=1 two cycles after the last beat; rk_idx=3, rk_dec=0 → rk_data=...03 one cycle later.
2. After load, rk_dec=1, rk_idx=0 → rk_data=...0E; rk_idx=14 → ...00; reads back-to-back on consecutive cycles → rk_valid held high.
3. kg_valid high for 17 beats (beats 15/16 = 128'hDEAD...) → slot 14 still holds ...0E; no ld_err.
4. kg_valid dropped after 7 beats → ld_err pulse, rk_ready stays 0; rk_req → rk_err pulse, rk_valid=0.
5. rk_idx=15 with rk_ready=1 → rk_err=1, rk_valid=0; a reload burst started while a read is in flight → read returns the old slot 0 value, rk_ready=0 next cycle.
6. kz_clear in FULL → rk_ready=0. With AES_RKEY_ZEROIZE_EN: after 15 cycles a reload aborted at 0 beats leaves all slots at 0 (checked by a backdoor read). Without it: storage unchanged, state EMPTY.
